hazard_sequencer: RTL

Pipeline hazard controller for the 5-stage MIPS pipeline. It sequences the PC, IF/ID and ID/EX pipeline registers: it inserts load-use bubbles into ID/EX, flushes IF/ID on taken branches and jumps, and freezes the whole front end while data memory is busy. It sits beside the decode stage and drives the write enables, flush and bubble controls of the PC and pipeline registers. It also keeps stall and flush statistics.

---
 rtl/hazard_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hazard_sequencer.sv
// Hazard controller for the 5-stage pipeline: load-use bubbles, branch/jump
// flushes and front-end freeze on data-memory wait, plus stall/flush statistics.
module hazard_sequencer #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned MEM_TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        idExMemRead,
   input  logic [4:0]  idExRt,
   input  logic [4:0]  ifIdRs,
   input  logic [4:0]  ifIdRt,
   input  logic        ifIdUsesRt,
   input  logic        branchTaken,
   input  logic        jump,
   input  logic        memBusy,
   output logic        pcWrite,
   output logic        ifIdWrite,
   output logic        ifIdFlush,
   output logic        idExWrite,
   output logic        idExBubble,
   output logic        memTimeout,
   output logic [31:0] stallCycles,
   output logic [15:0] flushCount
);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_MEMWAIT = 2'd1,
      S_FLUSH   = 2'd2
   } state_t;

   localparam logic [1:0] FLUSH_LOAD  = 2'(FLUSH_CYCLES - 1);
   localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

   state_t      r_state;
   logic [7:0]  r_wait;
   logic [1:0]  r_flush;
   logic        r_memTimeout;
   logic [31:0] r_stallCycles;
   logic [15:0] r_flushCount;

   state_t      w_next;
   logic [7:0]  w_waitNext;
   logic [1:0]  w_flushNext;
   logic [8:0]  w_waitInc;
   logic        w_luHaz;
   logic        w_setTimeout;
   logic        w_flushEvent;
   logic        w_pcWrite;
   logic        w_ifIdWrite;
   logic        w_ifIdFlush;
   logic        w_idExWrite;
   logic        w_idExBubble;

   assign w_luHaz = idExMemRead && (idExRt != 5'd0) &&
                    ((idExRt == ifIdRs) || (ifIdUsesRt && (idExRt == ifIdRt)));

   // A busy cycle outside MEMWAIT opens a new wait episode counted from 1.
   assign w_waitInc = (r_state == S_MEMWAIT) ? ({1'b0, r_wait} + 9'd1) : 9'd1;

   always_comb begin
      w_next       = S_RUN;
      w_waitNext   = r_wait;
      w_flushNext  = r_flush;
      w_setTimeout = 1'b0;
      w_flushEvent = 1'b0;
      w_pcWrite    = 1'b1;
      w_ifIdWrite  = 1'b1;
      w_ifIdFlush  = 1'b0;
      w_idExWrite  = 1'b1;
      w_idExBubble = 1'b0;

      if (memBusy && (r_state inside {S_RUN, S_MEMWAIT, S_FLUSH})) begin
         w_pcWrite   = 1'b0;
         w_ifIdWrite = 1'b0;
         w_idExWrite = 1'b0;
         w_flushNext = '0;
         if (w_waitInc >= TIMEOUT_LIM) begin
            w_setTimeout = 1'b1;
            w_next       = S_RUN;
            w_waitNext   = '0;
         end else begin
            w_next     = S_MEMWAIT;
            w_waitNext = w_waitInc[7:0];
         end
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_luHaz) begin
                  w_pcWrite    = 1'b0;
                  w_ifIdWrite  = 1'b0;
                  w_idExBubble = 1'b1;
               end else if (branchTaken || jump) begin
                  w_ifIdFlush  = 1'b1;
                  w_flushEvent = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     w_next      = S_FLUSH;
                     w_flushNext = FLUSH_LOAD;
                  end
               end
            end
            S_MEMWAIT: begin
               w_next     = S_RUN;
               w_waitNext = '0;
            end
            S_FLUSH: begin
               w_ifIdFlush  = 1'b1;
               w_idExBubble = 1'b1;
               w_flushNext  = r_flush - 2'd1;
               w_next       = (r_flush <= 2'd1) ? S_RUN : S_FLUSH;
            end
            default: begin
               w_next = S_RUN;
            end
         endcase
      end

      if (!rst) begin
         w_pcWrite    = 1'b0;
         w_ifIdWrite  = 1'b0;
         w_idExWrite  = 1'b0;
         w_ifIdFlush  = 1'b1;
         w_idExBubble = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= S_RUN;
         r_wait        <= '0;
         r_flush       <= '0;
         r_memTimeout  <= 1'b0;
         r_stallCycles <= '0;
         r_flushCount  <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_waitNext;
         r_flush <= w_flushNext;
         if (w_setTimeout) begin
            r_memTimeout <= 1'b1;
         end
         if (!w_pcWrite && (r_stallCycles != '1)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
         end
         if (w_flushEvent && (r_flushCount != '1)) begin
            r_flushCount <= r_flushCount + 16'd1;
         end
      end
   end

   assign pcWrite     = w_pcWrite;
   assign ifIdWrite   = w_ifIdWrite;
   assign ifIdFlush   = w_ifIdFlush;
   assign idExWrite   = w_idExWrite;
   assign idExBubble  = w_idExBubble;
   assign memTimeout  = r_memTimeout;
   assign stallCycles = r_stallCycles;
   assign flushCount  = r_flushCount;

endmodule
